// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: state encodings, opcode constants and helpers shared by the fetch unit
package instr_fetch_unit_pkg;

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    localparam logic [5:0]  OPC_J  = 6'b000010;
    localparam logic [31:0] PC_INC = 32'd4;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// next_pc_calc: sequential / branch / jump next-PC selection, purely combinational
module next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic        nPC_sel,
    input  logic        is_jump,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + PC_INC;
    assign next_pc  = is_jump ? {pc_plus4[31:28], instr_index, 2'b00}
                    : nPC_sel ? pc_plus4 + branch_offset(imm16)
                    : pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and fetch sequencer; IFETCH_JUMP_EN enables j-opcode handling
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15,
    parameter int          WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        retire,
    input  logic        nPC_sel,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_err
);

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       next_pc;
    logic              is_jump;
    logic              wait_last;

    assign opcode      = instr[31:26];
    assign imm16       = instr[15:0];
    assign imem_req    = state == FETCH;
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = state == EXEC;
    assign wait_last   = wait_cnt == WAIT_W'(MAX_WAIT - 1);

`ifdef IFETCH_JUMP_EN
    assign is_jump = opcode == OPC_J;
`else
    assign is_jump = 1'b0;
`endif

    next_pc_calc u_next_pc (
        .pc          (pc),
        .imm16       (imm16),
        .instr_index (instr[25:0]),
        .nPC_sel     (nPC_sel),
        .is_jump     (is_jump),
        .next_pc     (next_pc)
    );

    // Sequencer: BOOT -> FETCH -> EXEC -> FETCH ..., timeout traps in ERR until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= {RESET_PC[31:2], 2'b00};
            instr     <= '0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else if (state == BOOT) begin
            state <= FETCH;
        end else if (state == FETCH) begin
            if (imem_ready) begin
                instr    <= imem_rdata;
                wait_cnt <= '0;
                state    <= EXEC;
            end else if (wait_last) begin
                fetch_err <= 1'b1;
                state     <= ERR;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else if (state == EXEC && retire) begin
            pc    <= {next_pc[31:2], 2'b00};
            state <= FETCH;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench with a flat next-address model
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        retire = 1'b0;
    logic        nPC_sel = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic        instr_valid;
    logic [31:0] pc;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_pc = RST_PC;

    instr_fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(15), .WAIT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .retire(retire),
        .nPC_sel(nPC_sel), .instr(instr), .opcode(opcode), .imm16(imm16),
        .instr_valid(instr_valid), .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w, input logic sel);
        longint seq;
        longint t;
        seq = longint'(p) + 4;
`ifdef IFETCH_JUMP_EN
        if (w[31:26] == 6'd2) begin
            t = (seq & 64'hF000_0000) + longint'(w[25:0]) * 4;
            return t[31:0];
        end
`endif
        t = sel ? seq + 4 * longint'($signed(w[15:0])) : seq;
        return t[31:0];
    endfunction

    function automatic logic [15:0] imm_to(input logic [31:0] from, input logic [31:0] target);
        logic [31:0] d;
        d = (target - from - 32'd4) >> 2;
        return d[15:0];
    endfunction

    task automatic do_instr(input logic [31:0] w, input logic sel, input int waits, input int holds);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            retire = 1'($urandom);
            nPC_sel = 1'($urandom);
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL fetch_wait req=%0b addr=%h valid=%0b expected req=1 addr=%h valid=0",
                         imem_req, imem_addr, instr_valid, exp_pc);
            end
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        retire = 1'($urandom);
        step();
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== w || opcode !== w[31:26] ||
            imm16 !== w[15:0] || pc !== exp_pc || imem_addr !== 32'd0) begin
            failures++;
            $display("FAIL exec_entry valid=%0b req=%0b instr=%h op=%h imm=%h pc=%h addr=%h expected valid=1 req=0 instr=%h pc=%h addr=0",
                     instr_valid, imem_req, instr, opcode, imm16, pc, imem_addr, w, exp_pc);
        end
        for (int i = 0; i < holds; i++) begin
            retire = 1'b0;
            nPC_sel = 1'($urandom);
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr !== w || pc !== exp_pc || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL exec_hold valid=%0b instr=%h pc=%h req=%0b expected valid=1 instr=%h pc=%h req=0",
                         instr_valid, instr, pc, imem_req, w, exp_pc);
            end
        end
        imem_ready = 1'b0;
        retire = 1'b1;
        nPC_sel = sel;
        step();
        retire = 1'b0;
        exp_pc = model_next(exp_pc, w, sel);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0 || pc[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL next_fetch req=%0b addr=%h valid=%0b expected req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, exp_pc);
        end
    endtask

    task automatic branch_to(input logic [31:0] target);
        do_instr({6'h04, 10'($urandom), imm_to(exp_pc, target)}, 1'b1, 0, 0);
        checks++;
        if (imem_addr !== target) begin
            failures++;
            $display("FAIL branch_to addr=%h expected %h", imem_addr, target);
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0) begin
            failures++;
            $display("FAIL boot_cycle req=%0b valid=%0b instr=%h expected 0 0 0", imem_req, instr_valid, instr);
        end
        step();
        exp_pc = RST_PC;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL first_fetch req=%0b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        retire = 1'b1;
        step();
        step();
        checks++;
        if (pc !== RST_PC || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
            fetch_err !== 1'b0 || imem_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_values pc=%h instr=%h valid=%0b req=%0b err=%0b addr=%h expected all zero",
                     pc, instr, instr_valid, imem_req, fetch_err, imem_addr);
        end
        retire = 1'b0;
        release_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            do_instr({6'h00, 26'($urandom)}, 1'b0, 0, 0);
            checks++;
            if (imem_addr !== 32'(4 * (i + 1))) begin
                failures++;
                $display("FAIL seq_addr addr=%h expected %h", imem_addr, 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_branch();
        branch_to(32'h100);
        do_instr({6'h04, 10'h0, 16'hFFFE}, 1'b1, 0, 0);
        checks++;
        if (imem_addr !== 32'h0FC) begin
            failures++;
            $display("FAIL branch_back addr=%h expected 000000fc", imem_addr);
        end
        branch_to(32'h100);
        do_instr({6'h04, 10'h0, 16'hFFFE}, 1'b0, 0, 0);
        checks++;
        if (imem_addr !== 32'h104) begin
            failures++;
            $display("FAIL branch_not_taken addr=%h expected 00000104", imem_addr);
        end
    endtask

    task automatic test_wait();
        branch_to(32'h20);
        do_instr({6'h23, 26'($urandom)}, 1'b0, 3, 1);
        checks++;
        if (imem_addr !== 32'h24 || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL wait_result addr=%h err=%0b expected addr=00000024 err=0", imem_addr, fetch_err);
        end
    endtask

    task automatic test_jump();
        logic sel;
        logic [31:0] want;
        sel = 1'($urandom);
        branch_to(32'h100);
        do_instr(32'h0800_0010, sel, 0, 0);
`ifdef IFETCH_JUMP_EN
        want = 32'h40;
`else
        want = sel ? 32'h144 : 32'h104;
`endif
        checks++;
        if (imem_addr !== want) begin
            failures++;
            $display("FAIL jump_target addr=%h expected %h", imem_addr, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            do_instr($urandom, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    endtask

    task automatic test_reset_midfetch();
        branch_to(32'h40);
        imem_ready = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== RST_PC || instr !== 32'd0 || imem_addr !== 32'd0) begin
            failures++;
            $display("FAIL midfetch_reset req=%0b valid=%0b pc=%h instr=%h addr=%h expected reset values",
                     imem_req, instr_valid, pc, instr, imem_addr);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        step();
        checks++;
        if (instr !== 32'd0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_capture instr=%h valid=%0b expected 0 0", instr, instr_valid);
        end
        release_reset();
        do_instr($urandom, 1'($urandom), 0, 0);
    endtask

    task automatic test_timeout();
        int cnt;
        branch_to(32'h40);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            imem_ready = 1'b0;
            retire = 1'($urandom);
            step();
            if (!imem_req) break;
            cnt++;
        end
        checks++;
        if (cnt !== 15 || fetch_err !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h40) begin
            failures++;
            $display("FAIL timeout fetch_cycles=%0d err=%0b req=%0b pc=%h expected 15 1 0 00000040",
                     cnt, fetch_err, imem_req, pc);
        end
        imem_ready = 1'b1;
        retire = 1'b1;
        for (int i = 0; i < 3; i++) step();
        retire = 1'b0;
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h40) begin
            failures++;
            $display("FAIL err_sticky err=%0b req=%0b valid=%0b pc=%h expected 1 0 0 00000040",
                     fetch_err, imem_req, instr_valid, pc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (fetch_err !== 1'b0 || pc !== RST_PC) begin
            failures++;
            $display("FAIL err_clear err=%0b pc=%h expected 0 %h", fetch_err, pc, RST_PC);
        end
        imem_ready = 1'b0;
        step();
        release_reset();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wait();
        test_jump();
        test_random();
        test_reset_midfetch();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
